// File: rtl/fir_filter_if.sv
// AXI-lite config, AXI-stream sample and tap/data RAM bundle of fir_filter.
interface fir_filter_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   ss_tvalid;
    logic                   ss_tready;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   sm_tvalid;
    logic                   sm_tready;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;
    logic [3:0]             tap_WE;
    logic                   tap_EN;
    logic [pDATA_WIDTH-1:0] tap_Di;
    logic [pADDR_WIDTH-1:0] tap_A;
    logic [pDATA_WIDTH-1:0] tap_Do;
    logic [3:0]             data_WE;
    logic                   data_EN;
    logic [pDATA_WIDTH-1:0] data_Di;
    logic [pADDR_WIDTH-1:0] data_A;
    logic [pDATA_WIDTH-1:0] data_Do;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_Do, data_Do,
        output awready, wready, arready, rvalid, rdata,
        output ss_tready, sm_tvalid, sm_tdata, sm_tlast,
        output tap_WE, tap_EN, tap_Di, tap_A,
        output data_WE, data_EN, data_Di, data_A
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_Do, data_Do,
        input  awready, wready, arready, rvalid, rdata,
        input  ss_tready, sm_tvalid, sm_tdata, sm_tlast,
        input  tap_WE, tap_EN, tap_Di, tap_A,
        input  data_WE, data_EN, data_Di, data_A
    );
endinterface

// File: rtl/fir_filter.sv
// 11-tap FIR with AXI-lite config, AXI-stream samples, one MAC per cycle.
// Define FIR_CFG_PROTECT_EN to return all-ones on tap reads while busy.
module fir_filter #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic        axis_clk,
    input  logic        axis_rst_n,
    fir_filter_if.slave bus
);
    localparam int CW = $clog2(Tape_Num + 1);
    localparam logic [CW-1:0] LAST = CW'(Tape_Num - 1);
    localparam logic [CW-1:0] C1 = 1;
    localparam logic [pDATA_WIDTH-1:0] ONE = 1;
    localparam logic [pADDR_WIDTH-1:0] A_CTRL = 'h00;
    localparam logic [pADDR_WIDTH-1:0] A_LEN  = 'h10;
    localparam logic [pADDR_WIDTH-1:0] A_TAP0 = 'h20;
    localparam logic [pADDR_WIDTH-1:0] A_TAPN = pADDR_WIDTH'(32 + Tape_Num - 1);
`ifdef FIR_CFG_PROTECT_EN
    localparam logic [pDATA_WIDTH-1:0] BUSY_TAP = '1;
`else
    localparam logic [pDATA_WIDTH-1:0] BUSY_TAP = '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_WAIT, S_MAC, S_TAIL, S_OUT, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic ap_start_q, ap_start_d, ap_done_q, ap_done_d, ap_idle_q, ap_idle_d;
    logic wr_ack_q, wr_ack_d, ar_ack_q, ar_ack_d;
    logic rd_pend_q, rd_pend_d, rd_ok_q, rd_ok_d, rvalid_q, rvalid_d;
    logic [pADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d, data_length_q, data_length_d;
    logic [pDATA_WIDTH-1:0] acc_q, acc_d, n_q, n_d, mac;
    logic [CW-1:0] cnt_q, cnt_d, wptr_q, wptr_d, didx;
    logic wr_fire, ar_fire, wr_tap, ar_tap, out_fire, last_out;
    logic unused_tlast;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= A_TAP0) && (a <= A_TAPN);
    endfunction

    function automatic logic [CW-1:0] tap_idx(input logic [pADDR_WIDTH-1:0] a);
        return CW'(a - A_TAP0);
    endfunction

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [CW-1:0] i);
        return pADDR_WIDTH'({i, 2'b00});
    endfunction

    assign unused_tlast = bus.ss_tlast;
    assign bus.awready  = wr_ack_q;
    assign bus.wready   = wr_ack_q;
    assign bus.arready  = ar_ack_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;

    assign wr_fire  = wr_ack_q & bus.awvalid & bus.wvalid;
    assign ar_fire  = ar_ack_q & bus.arvalid;
    assign wr_tap   = wr_fire & ap_idle_q & is_tap(bus.awaddr);
    assign ar_tap   = ar_fire & ap_idle_q & is_tap(bus.araddr);
    assign out_fire = (state_q == S_OUT) & bus.sm_tready;
    assign last_out = (n_q + ONE) >= data_length_q;
    assign mac      = acc_q + bus.tap_Do * bus.data_Do;
    // Circular buffer: tap k pairs with the sample k slots behind the write pointer.
    assign didx     = (wptr_q >= cnt_q) ? wptr_q - cnt_q
                                        : wptr_q + CW'(Tape_Num) - cnt_q;

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q       <= S_IDLE;
            ap_start_q    <= 1'b0;
            ap_done_q     <= 1'b0;
            ap_idle_q     <= 1'b1;
            data_length_q <= '0;
            wr_ack_q      <= 1'b0;
            ar_ack_q      <= 1'b0;
            rd_pend_q     <= 1'b0;
            rd_ok_q       <= 1'b0;
            rvalid_q      <= 1'b0;
            rd_addr_q     <= '0;
            rdata_q       <= '0;
            acc_q         <= '0;
            n_q           <= '0;
            cnt_q         <= '0;
            wptr_q        <= '0;
        end else begin
            state_q       <= state_d;
            ap_start_q    <= ap_start_d;
            ap_done_q     <= ap_done_d;
            ap_idle_q     <= ap_idle_d;
            data_length_q <= data_length_d;
            wr_ack_q      <= wr_ack_d;
            ar_ack_q      <= ar_ack_d;
            rd_pend_q     <= rd_pend_d;
            rd_ok_q       <= rd_ok_d;
            rvalid_q      <= rvalid_d;
            rd_addr_q     <= rd_addr_d;
            rdata_q       <= rdata_d;
            acc_q         <= acc_d;
            n_q           <= n_d;
            cnt_q         <= cnt_d;
            wptr_q        <= wptr_d;
        end
    end

    // A pending write blocks the read address handshake so writes win.
    always_comb begin
        wr_ack_d  = bus.awvalid & bus.wvalid & ~wr_ack_q;
        ar_ack_d  = bus.arvalid & ~ar_ack_q & ~rd_pend_q & ~rvalid_q
                  & ~wr_ack_q & ~(bus.awvalid & bus.wvalid);
        rd_pend_d = ar_fire;
        rd_addr_d = ar_fire ? bus.araddr : rd_addr_q;
        rd_ok_d   = ar_fire ? ap_idle_q : rd_ok_q;
        rvalid_d  = rvalid_q & ~bus.rready;
        rdata_d   = rdata_q;
        if (rd_pend_q) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            unique case (1'b1)
                rd_addr_q == A_CTRL:
                    rdata_d[2:0] = ap_idle_q ? {ap_idle_q, ap_done_q, ap_start_q} : 3'b0;
                rd_addr_q == A_LEN: rdata_d = data_length_q;
                is_tap(rd_addr_q):  rdata_d = rd_ok_q ? bus.tap_Do : BUSY_TAP;
                default: ;
            endcase
        end
        ap_start_d    = ap_start_q;
        ap_done_d     = ap_done_q;
        ap_idle_d     = ap_idle_q;
        data_length_d = data_length_q;
        if (wr_fire && ap_idle_q) begin
            if (bus.awaddr == A_CTRL && bus.wdata[0]) begin
                ap_start_d = 1'b1;
                ap_done_d  = 1'b0;
                ap_idle_d  = 1'b0;
            end
            if (bus.awaddr == A_LEN) data_length_d = bus.wdata;
        end
        if (state_q == S_IDLE && ap_start_q) ap_start_d = 1'b0;
        if (out_fire && last_out) ap_done_d = 1'b1;
        if (state_q == S_DONE) ap_idle_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (ap_start_q) state_d = S_CLR;
            S_CLR:  if (cnt_q == LAST) state_d = S_WAIT;
            S_WAIT: if (bus.ss_tvalid) state_d = S_MAC;
            S_MAC:  if (cnt_q == LAST) state_d = S_TAIL;
            S_TAIL: state_d = S_OUT;
            S_OUT:  if (bus.sm_tready) state_d = last_out ? S_DONE : S_WAIT;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        wptr_d        = wptr_q;
        n_d           = n_q;
        acc_d         = acc_q;
        bus.ss_tready = 1'b0;
        bus.sm_tvalid = 1'b0;
        bus.sm_tlast  = 1'b0;
        bus.sm_tdata  = acc_q;
        bus.data_EN   = 1'b0;
        bus.data_WE   = 4'h0;
        bus.data_A    = '0;
        bus.data_Di   = '0;
        bus.tap_EN    = wr_tap | ar_tap;
        bus.tap_WE    = wr_tap ? 4'hF : 4'h0;
        bus.tap_A     = word_addr(tap_idx(wr_tap ? bus.awaddr : bus.araddr));
        bus.tap_Di    = bus.wdata;
        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                wptr_d = '0;
                n_d    = '0;
            end
            S_CLR: begin
                bus.data_EN = 1'b1;
                bus.data_WE = 4'hF;
                bus.data_A  = word_addr(cnt_q);
                cnt_d       = (cnt_q == LAST) ? '0 : cnt_q + C1;
            end
            S_WAIT: begin
                bus.ss_tready = 1'b1;
                if (bus.ss_tvalid) begin
                    bus.data_EN = 1'b1;
                    bus.data_WE = 4'hF;
                    bus.data_A  = word_addr(wptr_q);
                    bus.data_Di = bus.ss_tdata;
                    cnt_d       = '0;
                    acc_d       = '0;
                end
            end
            S_MAC: begin
                bus.tap_EN  = 1'b1;
                bus.tap_WE  = 4'h0;
                bus.tap_A   = word_addr(cnt_q);
                bus.data_EN = 1'b1;
                bus.data_A  = word_addr(didx);
                if (cnt_q != '0) acc_d = mac;
                cnt_d = cnt_q + C1;
            end
            S_TAIL: acc_d = mac;
            S_OUT: begin
                bus.sm_tvalid = 1'b1;
                bus.sm_tlast  = (n_q == data_length_q - ONE);
                if (bus.sm_tready) begin
                    n_d    = n_q + ONE;
                    wptr_d = (wptr_q == LAST) ? '0 : wptr_q + C1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fir_filter.sv
// Randomized bench for fir_filter: external RAM models plus a convolution
// reference computed directly from the tap list and the sample history.
module tb_fir_filter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_filter_if bus ();
    fir_filter dut (.axis_clk(clk), .axis_rst_n(rst_n), .bus(bus));

    logic [31:0] tap_mem  [0:15];
    logic [31:0] data_mem [0:15];

    always @(posedge clk) begin
        if (bus.tap_EN) begin
            if (bus.tap_WE == 4'hF) tap_mem[bus.tap_A[5:2]] <= bus.tap_Di;
            bus.tap_Do <= tap_mem[bus.tap_A[5:2]];
        end
        if (bus.data_EN) begin
            if (bus.data_WE == 4'hF) data_mem[bus.data_A[5:2]] <= bus.data_Di;
            bus.data_Do <= data_mem[bus.data_A[5:2]];
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int h [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int xs [$];
`ifdef FIR_CFG_PROTECT_EN
    logic [31:0] busy_tap = 32'hFFFF_FFFF;
`else
    logic [31:0] busy_tap = 32'h0;
`endif

    function automatic int golden(int n);
        int acc = 0;
        for (int k = 0; k < 11; k++)
            if (n - k >= 0) acc += h[k] * xs[n - k];
        return acc;
    endfunction

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        bit done = 0;
        @(negedge clk);
        bus.awaddr = a; bus.wdata = d; bus.awvalid = 1; bus.wvalid = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.awready && bus.wready) begin
                @(posedge clk); #1; done = 1;
            end else @(negedge clk);
        end
        bus.awvalid = 0; bus.wvalid = 0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL axi_write addr=%h: no awready/wready, required a handshake", a);
        end
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
        bit got_ar = 0;
        bit got_r = 0;
        d = 'x;
        @(negedge clk);
        bus.araddr = a; bus.arvalid = 1;
        for (int i = 0; i < 20 && !got_ar; i++) begin
            if (bus.arready) begin
                @(posedge clk); #1; got_ar = 1;
            end else @(negedge clk);
        end
        bus.arvalid = 0;
        for (int i = 0; i < 20 && got_ar && !got_r; i++) begin
            @(negedge clk);
            if (bus.rvalid) begin
                d = bus.rdata; bus.rready = 1;
                @(posedge clk); #1; bus.rready = 0; got_r = 1;
            end
        end
        if (!got_r) begin
            vectors++; miscompares++;
            $display("FAIL axi_read addr=%h: no arready/rvalid, required a response", a);
        end
    endtask

    task automatic push_sample(input int x);
        bit done = 0;
        @(negedge clk);
        bus.ss_tdata = x; bus.ss_tvalid = 1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.ss_tready) begin
                @(posedge clk); #1; done = 1;
            end else @(negedge clk);
        end
        bus.ss_tvalid = 0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL ss_tready timeout: got 0, required 1");
        end
    endtask

    task automatic pop_output(input int stall, output logic [31:0] y,
                              output logic last, output bit stable);
        bit ok = 0;
        stable = 1; y = 'x; last = 'x;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.sm_tvalid) ok = 1;
        end
        if (ok) begin
            y = bus.sm_tdata; last = bus.sm_tlast;
            repeat (stall) begin
                @(negedge clk);
                if (bus.sm_tdata !== y || bus.sm_tvalid !== 1'b1 || bus.ss_tready !== 1'b0)
                    stable = 0;
            end
            bus.sm_tready = 1;
            @(posedge clk); #1; bus.sm_tready = 0;
        end else begin
            vectors++; miscompares++;
            $display("FAIL sm_tvalid timeout: got 0, required 1");
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.awready, bus.wready, bus.arready, bus.rvalid, bus.ss_tready,
             bus.sm_tvalid, bus.sm_tlast, bus.tap_EN, bus.data_EN} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_handshakes got=%b required=0", {bus.awready, bus.wready,
                     bus.arready, bus.rvalid, bus.ss_tready, bus.sm_tvalid, bus.sm_tlast,
                     bus.tap_EN, bus.data_EN});
        end
        vectors++;
        if ({bus.tap_WE, bus.data_WE} !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_we got=%h required=00", {bus.tap_WE, bus.data_WE});
        end
        rst_n = 1;
        axi_read(12'h000, rd);
        vectors++;
        if (rd !== 32'h4) begin
            miscompares++; $display("FAIL reset_ap_ctrl got=%h required=4", rd);
        end
        axi_read(12'h010, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++; $display("FAIL reset_data_length got=%h required=0", rd);
        end
    endtask

    task automatic test_taps();
        logic [31:0] rd;
        for (int k = 0; k < 11; k++) axi_write(12'(32 + k), h[k]);
        for (int k = 0; k < 11; k++) begin
            axi_read(12'(32 + k), rd);
            vectors++;
            if (rd !== 32'(h[k])) begin
                miscompares++; $display("FAIL tap_readback k=%0d got=%h required=%h", k, rd, h[k]);
            end
        end
        axi_read(12'h02C, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++; $display("FAIL unmapped_read got=%h required=0", rd);
        end
    endtask

    task automatic test_rw_collision();
        logic [31:0] rd;
        logic [31:0] v = $urandom;
        fork
            axi_write(12'h02A, v);
            axi_read(12'h02A, rd);
        join
        vectors++;
        if (rd !== v) begin
            miscompares++; $display("FAIL write_before_read got=%h required=%h", rd, v);
        end
        axi_write(12'h02A, 32'(h[10]));
    endtask

    task automatic test_impulse();
        logic [31:0] y, rd;
        logic last;
        bit stable;
        xs = {};
        axi_write(12'h010, 32'd11);
        axi_write(12'h000, 32'd1);
        for (int n = 0; n < 11; n++) begin
            xs.push_back(n == 0 ? 1 : 0);
            push_sample(xs[n]);
            pop_output($urandom_range(0, 2), y, last, stable);
            vectors++;
            if (y !== 32'(h[n])) begin
                miscompares++; $display("FAIL impulse_y n=%0d got=%h required=%h", n, y, h[n]);
            end
            vectors++;
            if (last !== (n == 10)) begin
                miscompares++; $display("FAIL impulse_tlast n=%0d got=%b required=%b", n, last, n == 10);
            end
        end
        axi_read(12'h000, rd);
        vectors++;
        if (rd[3:0] !== 4'b0110) begin
            miscompares++; $display("FAIL impulse_done got=%h required=6", rd[3:0]);
        end
    endtask

    task automatic test_triangle();
        logic [31:0] y, rd;
        logic last;
        bit stable;
        int p = 2 * $urandom_range(4, 20);
        int a = $urandom_range(1, 500);
        xs = {};
        axi_write(12'h010, 32'd600);
        axi_write(12'h000, 32'd1);
        for (int n = 0; n < 600; n++) begin
            int ph = n % p;
            int st = (n == 100) ? 5 : $urandom_range(0, 2);
            xs.push_back(((ph < p / 2) ? a * ph : a * (p - ph)) - a * p / 4);
            push_sample(xs[n]);
            pop_output(st, y, last, stable);
            vectors++;
            if (y !== 32'(golden(n))) begin
                miscompares++; $display("FAIL tri_y n=%0d got=%h required=%h", n, y, golden(n));
            end
            vectors++;
            if (last !== (n == 599)) begin
                miscompares++; $display("FAIL tri_tlast n=%0d got=%b required=%b", n, last, n == 599);
            end
            if (st > 0) begin
                vectors++;
                if (!stable) begin
                    miscompares++;
                    $display("FAIL stall_hold n=%0d got=unstable required=stable sm_tdata, ss_tready=0", n);
                end
            end
            if (n == 300) begin
                axi_read(12'h000, rd);
                vectors++;
                if (rd[3:0] !== 4'h0) begin
                    miscompares++; $display("FAIL busy_ap_ctrl got=%h required=0", rd[3:0]);
                end
                axi_read(12'h023, rd);
                vectors++;
                if (rd !== busy_tap) begin
                    miscompares++; $display("FAIL busy_tap_read got=%h required=%h", rd, busy_tap);
                end
                axi_write(12'h020, 32'h1234);
            end
        end
        axi_read(12'h000, rd);
        vectors++;
        if (rd[3:0] !== 4'b0110) begin
            miscompares++; $display("FAIL tri_done got=%h required=6", rd[3:0]);
        end
        axi_read(12'h020, rd);
        vectors++;
        if (rd !== 32'(h[0])) begin
            miscompares++; $display("FAIL busy_write_dropped got=%h required=%h", rd, h[0]);
        end
    endtask

    task automatic test_reset_rerun();
        logic [31:0] y, rd;
        logic last;
        bit stable;
        xs = {};
        axi_write(12'h010, 32'd40);
        axi_write(12'h000, 32'd1);
        for (int n = 0; n < 15; n++) begin
            xs.push_back(int'($urandom));
            push_sample(xs[n]);
            pop_output(0, y, last, stable);
        end
        push_sample(int'($urandom));
        repeat (3) @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        axi_read(12'h000, rd);
        vectors++;
        if (rd !== 32'h4) begin
            miscompares++; $display("FAIL abort_idle got=%h required=4", rd);
        end
        axi_read(12'h024, rd);
        vectors++;
        if (rd !== 32'(h[4])) begin
            miscompares++; $display("FAIL abort_tap_kept got=%h required=%h", rd, h[4]);
        end
        xs = {};
        axi_write(12'h010, 32'd25);
        axi_write(12'h000, 32'd1);
        for (int n = 0; n < 25; n++) begin
            xs.push_back(int'($urandom));
            push_sample(xs[n]);
            pop_output($urandom_range(0, 3), y, last, stable);
            vectors++;
            if (y !== 32'(golden(n)) || last !== (n == 24)) begin
                miscompares++;
                $display("FAIL rerun n=%0d got=%h/%b required=%h/%b", n, y, last, golden(n), n == 24);
            end
        end
    endtask

    initial begin
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.rready = 0;
        bus.awaddr = '0; bus.wdata = '0; bus.araddr = '0;
        bus.ss_tvalid = 0; bus.ss_tdata = '0; bus.ss_tlast = 0; bus.sm_tready = 0;
        test_reset();
        test_taps();
        test_rw_collision();
        test_impulse();
        test_triangle();
        test_reset_rerun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1);
    end
endmodule

// File: doc/fir_filter.md
FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 Parameters SHALL be: pADDR_WIDTH, default 12, address width; pDATA_WIDTH, default 32, data width; Tape_Num, default 11, tap count.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be exactly (name direction width meaning):
- axis_clk  in  1  clock
- axis_rst_n  in  1  sync active-low reset
- awvalid/awready  in/out  1  AXI-lite write address handshake
- awaddr  in  12  AXI-lite write address
- wvalid/wready  in/out  1  AXI-lite write data handshake
- wdata  in  32  AXI-lite write data
- arvalid/arready  in/out  1  AXI-lite read address handshake
- araddr  in  12  AXI-lite read address
- rvalid/rready  out/in  1  AXI-lite read data handshake
- rdata  out  32  AXI-lite read data
- ss_tvalid/ss_tready  in/out  1  input stream handshake
- ss_tdata  in  32  input sample, signed
- ss_tlast  in  1  last input sample
- sm_tvalid/sm_tready  out/in  1  output stream handshake
- sm_tdata  out  32  output sample, signed
- sm_tlast  out  1  last output sample
- tap_WE/data_WE  out  4  tap/data RAM byte write enables
- tap_EN/data_EN  out  1  tap/data RAM enables
- tap_Di/data_Di  out  32  tap/data RAM write data
- tap_A/data_A  out  12  tap/data RAM byte address, word i = 4*i
- tap_Do/data_Do  in  32  tap/data RAM read data; external 11-word RAMs with 1-cycle registered read

Function
REQ-004 The register map SHALL be: 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle, rest 0); 0x10 data_length (32 bit); 0x20+k tap coefficient k, k=0..10, stored at tap RAM word k.
REQ-005 AXI-lite write: awready and wready SHALL pulse together for one cycle when awvalid and wvalid are both high; the write commits in that cycle.
REQ-006 AXI-lite read: arready SHALL pulse one cycle on arvalid; rvalid SHALL rise 1-2 cycles later with rdata; rvalid and rdata SHALL hold until rready; unmapped addresses return 0.
REQ-007 Writing 1 to ap_start while ap_idle=1 SHALL set ap_start, clear ap_done and clear ap_idle; ap_start SHALL self-clear when the engine begins; ap_start writes while busy SHALL be ignored.
REQ-008 After start, the engine SHALL zero data RAM words 0..10 before asserting ss_tready.
REQ-009 Per sample: ss_tready SHALL pulse for one cycle to accept x[n], which is written over the oldest entry of the 11-word circular buffer; wrap-around SHALL follow word 10 -> word 0.
REQ-010 Output SHALL be y[n] = sum over k=0..10 of h[k]*x[n-k], with x[m]=0 for m<0, using 32-bit two's-complement multiply/accumulate truncated to 32 bits; one MAC per cycle.
REQ-011 sm_tvalid SHALL hold with stable sm_tdata until sm_tready; the next sample SHALL NOT be accepted until the current output is taken.
REQ-012 sm_tlast SHALL be 1 exactly on output index data_length-1; ss_tlast SHALL be ignored for termination.
REQ-013 After the last output handshake, ap_done SHALL be set and ap_idle SHALL be set 1 cycle later; ap_done SHALL clear on the next ap_start.
REQ-014 While busy, reads of 0x00 SHALL return bits[3:0]=0.
REQ-015 While idle, tap RAM accesses SHALL be driven by AXI-lite; while busy, by the engine.
REQ-016 Simultaneous AXI-lite read and write SHALL serve the write first.

Reset
REQ-017 In reset: all valid/ready outputs, sm_tlast, all *_EN, all *_WE, ap_start and ap_done SHALL be 0; ap_idle SHALL be 1; data_length SHALL be 0.
REQ-018 Reset mid-run SHALL abort the run and return to idle; RAM contents SHALL be left unchanged.

Configuration
REQ-019 With macro FIR_CFG_PROTECT_EN defined, AXI-lite writes to 0x10 and 0x20-0x2A while busy SHALL be ignored, and tap reads while busy SHALL return 0xFFFFFFFF.
REQ-020 Without FIR_CFG_PROTECT_EN, such writes while busy SHALL be acknowledged and dropped, and tap reads while busy SHALL return 0.

Verification
REQ-021 The bench SHALL cover:
- Write taps {0,-10,-9,23,56,63,56,23,-9,-10,0} and read back -> exact match.
- data_length=11, ap_start, impulse x=1,0,...,0 -> y = tap sequence; sm_tlast on the 11th output.
- 600-sample triangular wave -> all outputs match the software golden model.
- Read 0x00 mid-stream -> bits[3:0]=0; after the final output -> ap_done=1 and ap_idle=1.
- sm_tready held low 5 cycles -> sm_tdata stable and ss_tready=0 meanwhile.
- Reset asserted mid-stream -> ap_idle=1; a rerun produces the correct results.
